// File: rtl/sys_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sys_ctrl
// Brief   : Decodes UART command frames into register-file writes and reads,
//           and forwards read data to the TX FIFO.
// Rev     : 1.0  initial release
// ============================================================================
module sys_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int RD_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [7:0]            RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic                  Wren,
    output logic                  Rden,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid,
    output logic [7:0]            TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  FIFO_FULL,
    output logic                  CMD_ERR
);

    localparam logic [7:0] CMD_WR = 8'hAA;
    localparam logic [7:0] CMD_RD = 8'hBB;
    localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4,
        TX_SEND = 3'd5
    } state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        rd_cnt, rd_cnt_next;
    logic [DATA_WIDTH-1:0]   rd_data, rd_data_next;
    logic                    wren_next, rden_next, tx_vld_next, err_next;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic [DATA_WIDTH-1:0]   wrdata_next;
    logic [7:0]              tx_data_next;
    logic                    addr_ok;

    // Address byte is legal only if no bit above the address field is set.
    assign addr_ok = (RX_P_DATA >> ADDR_WIDTH) == 8'd0;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            rd_data   <= '0;
            Wren      <= 1'b0;
            Rden      <= 1'b0;
            TX_D_VLD  <= 1'b0;
            CMD_ERR   <= 1'b0;
            Address   <= '0;
            WrData    <= '0;
            TX_P_DATA <= '0;
        end else begin
            state     <= state_next;
            rd_cnt    <= rd_cnt_next;
            rd_data   <= rd_data_next;
            Wren      <= wren_next;
            Rden      <= rden_next;
            TX_D_VLD  <= tx_vld_next;
            CMD_ERR   <= err_next;
            Address   <= addr_next;
            WrData    <= wrdata_next;
            TX_P_DATA <= tx_data_next;
        end
    end

    always_comb begin
        state_next   = state;
        rd_cnt_next  = rd_cnt;
        rd_data_next = rd_data;
        wren_next    = 1'b0;
        rden_next    = 1'b0;
        tx_vld_next  = 1'b0;
        err_next     = 1'b0;
        addr_next    = Address;
        wrdata_next  = WrData;
        tx_data_next = TX_P_DATA;

        case (state)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_WR)      state_next = WR_ADDR;
                    else if (RX_P_DATA == CMD_RD) state_next = RD_ADDR;
                    else                          err_next   = 1'b1;
                end
            end
            WR_ADDR, RD_ADDR: begin
                if (RX_D_VLD) begin
                    if (addr_ok) begin
                        addr_next = RX_P_DATA[ADDR_WIDTH-1:0];
                        if (state == WR_ADDR) begin
                            state_next = WR_DATA;
                        end else begin
                            state_next  = RD_WAIT;
                            rden_next   = 1'b1;
                            rd_cnt_next = '0;
                        end
                    end else begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wren_next   = 1'b1;
                    wrdata_next = RX_P_DATA[DATA_WIDTH-1:0];
                    state_next  = IDLE;
                end
            end
            RD_WAIT: begin
                // Bytes arriving mid-read are dropped without disturbing the read.
                if (RX_D_VLD) err_next = 1'b1;
                if (RdData_Valid) begin
                    rd_data_next = RdData;
                    state_next   = TX_SEND;
                end else if (rd_cnt == CNT_LAST) begin
                    err_next    = 1'b1;
                    rd_cnt_next = '0;
                    state_next  = IDLE;
                end else begin
                    rd_cnt_next = rd_cnt + 1'b1;
                end
            end
            TX_SEND: begin
                if (RX_D_VLD) err_next = 1'b1;
                if (!FIFO_FULL) begin
                    tx_vld_next                  = 1'b1;
                    tx_data_next                 = '0;
                    tx_data_next[DATA_WIDTH-1:0] = rd_data;
                    state_next                   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sys_ctrl.sv
`default_nettype none
// Bench for sys_ctrl: directed frames with literal expectations, then random
// traffic, all checked every cycle against a frame-level reference model.
module tb_sys_ctrl;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          RST;
    logic [7:0]    RX_P_DATA;
    logic          RX_D_VLD;
    logic          Wren, Rden;
    logic [AW-1:0] Address;
    logic [DW-1:0] WrData;
    logic [DW-1:0] RdData;
    logic          RdData_Valid;
    logic [7:0]    TX_P_DATA;
    logic          TX_D_VLD;
    logic          FIFO_FULL;
    logic          CMD_ERR;

    always #5 clk = ~clk;

    sys_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_TIMEOUT(TO)) dut (
        .clk(clk), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .Wren(Wren), .Rden(Rden), .Address(Address), .WrData(WrData),
        .RdData(RdData), .RdData_Valid(RdData_Valid), .TX_P_DATA(TX_P_DATA),
        .TX_D_VLD(TX_D_VLD), .FIFO_FULL(FIFO_FULL), .CMD_ERR(CMD_ERR)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    logic [7:0]    frame[$];
    bit            waiting = 0;
    bit            sending = 0;
    int            wait_cyc = 0;
    logic [DW-1:0] held = '0;
    logic          e_wren = 0, e_rden = 0, e_tx = 0, e_err = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wd = '0;
    logic [7:0]    e_txd = '0;

    always @(posedge clk or posedge RST) begin
        if (RST) begin
            frame.delete();
            waiting = 0; sending = 0; wait_cyc = 0; held = '0;
            e_wren = 0; e_rden = 0; e_tx = 0; e_err = 0;
            e_addr = '0; e_wd = '0; e_txd = '0;
        end else begin
            e_wren = 0; e_rden = 0; e_tx = 0; e_err = 0;
            if (waiting) begin
                if (RX_D_VLD) e_err = 1;
                if (RdData_Valid) begin
                    held = RdData; waiting = 0; sending = 1;
                end else begin
                    wait_cyc++;
                    if (wait_cyc == TO) begin e_err = 1; waiting = 0; end
                end
            end else if (sending) begin
                if (RX_D_VLD) e_err = 1;
                if (!FIFO_FULL) begin e_tx = 1; e_txd = 8'(held); sending = 0; end
            end else if (RX_D_VLD) begin
                logic [7:0] b;
                b = RX_P_DATA;
                frame.push_back(b);
                if (frame.size() == 1) begin
                    if (b != 8'hAA && b != 8'hBB) begin e_err = 1; frame.delete(); end
                end else if (frame.size() == 2) begin
                    if ((b >> AW) != 8'd0) begin
                        e_err = 1; frame.delete();
                    end else begin
                        e_addr = b[AW-1:0];
                        if (frame[0] == 8'hBB) begin
                            e_rden = 1; waiting = 1; wait_cyc = 0; frame.delete();
                        end
                    end
                end else begin
                    e_wren = 1; e_wd = b[DW-1:0]; frame.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        check("Wren",      Wren,      e_wren);
        check("Rden",      Rden,      e_rden);
        check("Address",   Address,   e_addr);
        check("WrData",    WrData,    e_wd);
        check("TX_D_VLD",  TX_D_VLD,  e_tx);
        check("TX_P_DATA", TX_P_DATA, e_txd);
        check("CMD_ERR",   CMD_ERR,   e_err);
    end

    // ---------------- register-file read responder ----------------
    bit            resp_en = 1;
    bit            resp_rand = 0;
    int            resp_delay = 0;
    logic [DW-1:0] resp_data = '0;

    initial begin
        RdData_Valid = 0;
        RdData = '0;
        forever begin
            @(negedge clk);
            if (Rden === 1'b1 && resp_en) begin
                int d;
                d = resp_rand ? int'($urandom_range(0, 5)) : resp_delay;
                repeat (d) @(negedge clk);
                RdData = resp_rand ? DW'($urandom) : resp_data;
                RdData_Valid = 1;
                @(negedge clk);
                RdData_Valid = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1;
        @(negedge clk);
        RX_D_VLD  = 0;
    endtask

    initial begin
        RST = 1; RX_P_DATA = '0; RX_D_VLD = 0; FIFO_FULL = 0;
        tick(2);
        check("rst_wren", Wren, 0);
        check("rst_addr", Address, 0);
        check("rst_txd", TX_P_DATA, 0);
        RST = 0;
        tick(1);

        // basic write
        send(8'hAA); send(8'h04); send(8'h07);
        check("w1_wren", Wren, 1);
        check("w1_addr", Address, 4);
        check("w1_data", WrData, 8'h07);
        check("w1_err", CMD_ERR, 0);
        tick(1);
        check("w1_wren_pulse", Wren, 0);

        // basic read, data two cycles after Rden
        resp_delay = 2; resp_data = 8'h07;
        send(8'hBB); send(8'h04);
        check("r1_rden", Rden, 1);
        tick(1);
        check("r1_rden_pulse", Rden, 0);
        tick(3);
        check("r1_tx", TX_D_VLD, 1);
        check("r1_txd", TX_P_DATA, 8'h07);
        tick(1);
        check("r1_tx_pulse", TX_D_VLD, 0);

        // read with FIFO back-pressure
        FIFO_FULL = 1; resp_delay = 0; resp_data = 8'h5A;
        send(8'hBB); send(8'h02);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("bp_hold", TX_D_VLD, 0);
        end
        FIFO_FULL = 0;
        tick(1);
        check("bp_tx", TX_D_VLD, 1);
        check("bp_txd", TX_P_DATA, 8'h5A);
        tick(1);
        check("bp_once", TX_D_VLD, 0);

        // bad command, bad address, then a good write
        send(8'h55);
        check("bad_cmd_err", CMD_ERR, 1);
        send(8'hAA); send(8'h09);
        check("bad_addr_err", CMD_ERR, 1);
        check("bad_addr_wren", Wren, 0);
        send(8'hAA); send(8'h01); send(8'h3C);
        check("w2_wren", Wren, 1);
        check("w2_addr", Address, 1);
        check("w2_data", WrData, 8'h3C);

        // read timeout, then a normal read
        resp_en = 0;
        send(8'hBB); send(8'h03);
        tick(3);
        check("to_early", CMD_ERR, 0);
        tick(1);
        check("to_err", CMD_ERR, 1);
        tick(1);
        check("to_no_tx", TX_D_VLD, 0);
        resp_en = 1; resp_delay = 1; resp_data = 8'hC3;
        send(8'hBB); send(8'h06);
        begin
            int k;
            k = 0;
            while (TX_D_VLD !== 1'b1 && k < 10) begin tick(1); k++; end
        end
        check("r2_tx", TX_D_VLD, 1);
        check("r2_txd", TX_P_DATA, 8'hC3);
        tick(1);

        // reset mid-frame
        send(8'hAA); send(8'h05);
        RST = 1;
        tick(1);
        check("mr_wren", Wren, 0);
        check("mr_rden", Rden, 0);
        check("mr_addr", Address, 0);
        check("mr_wd", WrData, 0);
        check("mr_tx", TX_D_VLD, 0);
        check("mr_txd", TX_P_DATA, 0);
        check("mr_err", CMD_ERR, 0);
        tick(1);
        RST = 0;
        tick(1);
        send(8'h11);
        check("mr_cmd_err", CMD_ERR, 1);
        check("mr_no_wren", Wren, 0);

        // random traffic
        resp_rand = 1;
        for (int c = 0; c < 4000; c++) begin
            RST       = ($urandom_range(0, 399) == 0);
            RX_D_VLD  = ($urandom_range(0, 2) == 0);
            FIFO_FULL = ($urandom_range(0, 9) < 3);
            case ($urandom_range(0, 19))
                0, 1, 2, 3, 4:                RX_P_DATA = 8'hAA;
                5, 6, 7, 8, 9:                RX_P_DATA = 8'hBB;
                10, 11, 12, 13, 14, 15, 16:   RX_P_DATA = 8'($urandom_range(0, 7));
                default:                      RX_P_DATA = 8'($urandom_range(0, 255));
            endcase
            tick(1);
        end
        RST = 0; RX_D_VLD = 0; FIFO_FULL = 0;
        tick(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
